// File: rtl/bob_except_seq.sv
// Retire-side sequencer for the 48-row x 10-lane exception store: in-order allocation, row clear, in-order retire.
// Build option BOB_EXCEPT_SEQ_INIT_EN: when defined, each allocated row is cleared through the init write port.
`ifndef EXCEPT_WIDTH
`define EXCEPT_WIDTH 16
`endif

module bob_except_seq #(
  parameter int DATA_WIDTH = `EXCEPT_WIDTH,
  parameter int EXC_BIT    = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [5:0]            alloc_row,
  input  logic                  head_done,
  output logic                  read_step,
  output logic [5:0]            read_addr,
  input  logic [DATA_WIDTH-1:0] read_data0,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] read_data3,
  input  logic [DATA_WIDTH-1:0] read_data4,
  input  logic [DATA_WIDTH-1:0] read_data5,
  input  logic [DATA_WIDTH-1:0] read_data6,
  input  logic [DATA_WIDTH-1:0] read_data7,
  input  logic [DATA_WIDTH-1:0] read_data8,
  input  logic [DATA_WIDTH-1:0] read_data9,
  output logic                  writeInit_wen,
  output logic [5:0]            writeInit_addr,
  output logic [DATA_WIDTH-1:0] writeInit_data,
  output logic                  ret_valid,
  input  logic                  ret_ready,
  output logic [5:0]            ret_row,
  output logic                  ret_exc,
  output logic [3:0]            ret_lane,
  output logic [DATA_WIDTH-1:0] ret_data,
  output logic [5:0]            count
);

  localparam logic [5:0] ROWS = 6'd48;
  localparam logic [5:0] LAST = 6'd47;

  typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

  state_t                state;
  logic [5:0]            head;
  logic [5:0]            tail;
  logic                  fire;
  logic                  pop;
  logic [DATA_WIDTH-1:0] lane [10];
  logic                  exc_any;
  logic [3:0]            exc_lane;
  logic [DATA_WIDTH-1:0] exc_data;

  function automatic logic [5:0] wrap_inc(input logic [5:0] p);
    return (p == LAST) ? 6'd0 : p + 6'd1;
  endfunction

  assign lane[0] = read_data0;
  assign lane[1] = read_data1;
  assign lane[2] = read_data2;
  assign lane[3] = read_data3;
  assign lane[4] = read_data4;
  assign lane[5] = read_data5;
  assign lane[6] = read_data6;
  assign lane[7] = read_data7;
  assign lane[8] = read_data8;
  assign lane[9] = read_data9;

  assign alloc_ready = (count != ROWS) && !flush;
  assign alloc_row   = tail;
  assign fire        = alloc_valid && alloc_ready;
  assign pop         = (state == HOLD) && ret_ready && !flush;
  assign read_step   = (state == IDLE) && (count != 6'd0) && head_done && !flush;
  assign read_addr   = head;

  // Scan high to low so the lowest flagged lane is the one left standing.
  always_comb begin
    exc_any  = 1'b0;
    exc_lane = 4'd0;
    exc_data = '0;
    for (int i = 9; i >= 0; i--) begin
      if (lane[i][EXC_BIT]) begin
        exc_any  = 1'b1;
        exc_lane = 4'(i);
        exc_data = lane[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= 6'd0;
      tail  <= 6'd0;
      count <= 6'd0;
    end else if (flush) begin
      head  <= 6'd0;
      tail  <= 6'd0;
      count <= 6'd0;
    end else begin
      if (fire) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      if (fire && !pop)      count <= count + 6'd1;
      else if (!fire && pop) count <= count - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ret_valid <= 1'b0;
      ret_row   <= 6'd0;
      ret_exc   <= 1'b0;
      ret_lane  <= 4'd0;
      ret_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      ret_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (read_step) state <= RD;
        RD: begin
          ret_row   <= head;
          ret_exc   <= exc_any;
          ret_lane  <= exc_lane;
          ret_data  <= exc_data;
          ret_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (ret_ready) begin
          ret_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign writeInit_data = '0;

`ifdef BOB_EXCEPT_SEQ_INIT_EN
  // Clear lands one cycle after the grant, so a same-edge read of that row sees the cleared value.
  logic       init_wen;
  logic [5:0] init_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_wen  <= 1'b0;
      init_addr <= 6'd0;
    end else if (flush) begin
      init_wen  <= 1'b0;
    end else begin
      init_wen <= fire;
      if (fire) init_addr <= tail;
    end
  end

  assign writeInit_wen  = init_wen;
  assign writeInit_addr = init_addr;
`else
  assign writeInit_wen  = 1'b0;
  assign writeInit_addr = 6'd0;
`endif

endmodule

// File: tb/tb_bob_except_seq.sv
// Bench for bob_except_seq: behavioural exception store, retire scoreboard, directed sequences.
module tb_bob_except_seq;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          head_done = 1'b0;
  logic          ret_ready = 1'b0;
  logic          alloc_ready;
  logic [5:0]    alloc_row;
  logic          read_step;
  logic [5:0]    read_addr;
  logic          writeInit_wen;
  logic [5:0]    writeInit_addr;
  logic [DW-1:0] writeInit_data;
  logic          ret_valid;
  logic [5:0]    ret_row;
  logic          ret_exc;
  logic [3:0]    ret_lane;
  logic [DW-1:0] ret_data;
  logic [5:0]    count;

  logic [DW-1:0]    rd_q [10];
  logic [DW-1:0]    mem  [48][10];
  logic [DW*10-1:0] pend_dat = '0;
  logic [5:0]       pend_row = 6'd0;
  int               pend_seq = 0;
  int               done_seq = 0;

  typedef struct packed {
    logic [5:0]    row;
    logic          exc;
    logic [3:0]    lane;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bob_except_seq #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_row(alloc_row),
    .head_done(head_done), .read_step(read_step), .read_addr(read_addr),
    .read_data0(rd_q[0]), .read_data1(rd_q[1]), .read_data2(rd_q[2]), .read_data3(rd_q[3]),
    .read_data4(rd_q[4]), .read_data5(rd_q[5]), .read_data6(rd_q[6]), .read_data7(rd_q[7]),
    .read_data8(rd_q[8]), .read_data9(rd_q[9]),
    .writeInit_wen(writeInit_wen), .writeInit_addr(writeInit_addr), .writeInit_data(writeInit_data),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_row(ret_row), .ret_exc(ret_exc),
    .ret_lane(ret_lane), .ret_data(ret_data), .count(count)
  );

  // Store model: init clear, then execution-unit lane writes, then read latch.
  always @(posedge clk) begin
    if (writeInit_wen)
      for (int i = 0; i < 10; i++) mem[writeInit_addr][i] = writeInit_data;
    if (pend_seq != done_seq) begin
      for (int i = 0; i < 10; i++) mem[pend_row][i] = pend_dat[i*DW +: DW];
      done_seq = pend_seq;
    end
    if (read_step)
      for (int i = 0; i < 10; i++) rd_q[i] <= mem[read_addr][i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [5:0] row, input logic [DW*10-1:0] lanes);
    pend_row = row;
    pend_dat = lanes;
    pend_seq++;
  endtask

  task automatic expect_ret(input logic [5:0] row, input logic exc, input logic [3:0] ln,
                            input logic [DW-1:0] data);
    exp_t e;
    e.row = row; e.exc = exc; e.lane = ln; e.data = data;
    sb.push_back(e);
  endtask

  // Retire monitor: every accepted record is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && ret_valid && ret_ready && !flush) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ret_unexpected: got row %0d expected no record", ret_row);
      end else begin
        e = sb.pop_front();
        check("ret_row",  32'(ret_row),  32'(e.row));
        check("ret_exc",  32'(ret_exc),  32'(e.exc));
        check("ret_lane", 32'(ret_lane), 32'(e.lane));
        check("ret_data", 32'(ret_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    check("rst_alloc_row",   32'(alloc_row), 0);
    check("rst_count",       32'(count), 0);
    check("rst_read_step",   32'(read_step), 0);
    check("rst_ret_valid",   32'(ret_valid), 0);
    check("rst_init_wen",    32'(writeInit_wen), 0);
    tick();
    rst = 1'b1;

    // Three back-to-back allocations
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("alloc_row", 32'(alloc_row), i);
      check("alloc_count", 32'(count), i);
`ifdef BOB_EXCEPT_SEQ_INIT_EN
      check("init_wen", 32'(writeInit_wen), (i > 0) ? 1 : 0);
      if (i > 0) check("init_addr", 32'(writeInit_addr), i - 1);
`else
      check("init_wen_off", 32'(writeInit_wen), 0);
`endif
      tick();
    end
    alloc_valid = 1'b0;
    @(negedge clk);
    check("alloc_count3", 32'(count), 3);
`ifdef BOB_EXCEPT_SEQ_INIT_EN
    check("init_wen_last", 32'(writeInit_wen), 1);
    check("init_addr_last", 32'(writeInit_addr), 2);
`endif
    tick();

    // Row 0: lanes 3 and 7 flagged, lowest wins
    set_row(6'd0, {16'h0009, 16'h0008, 16'h8777, 16'h0006, 16'h0005,
                   16'h0004, 16'h8123, 16'h0002, 16'h0001, 16'h0000});
    expect_ret(6'd0, 1'b1, 4'd3, 16'h8123);
    head_done = 1'b1;
    ret_ready = 1'b1;
    @(negedge clk);
    check("r0_read_step", 32'(read_step), 1);
    check("r0_read_addr", 32'(read_addr), 0);
    tick();
    head_done = 1'b0;
    @(negedge clk);
    check("r0_rd_step_low", 32'(read_step), 0);
    check("r0_rd_valid_low", 32'(ret_valid), 0);
    tick();
    @(negedge clk);
    check("r0_ret_valid", 32'(ret_valid), 1);
    check("r0_count_hold", 32'(count), 3);
    tick();
    @(negedge clk);
    check("r0_count_pop", 32'(count), 2);
    check("r0_valid_clr", 32'(ret_valid), 0);
    check("r0_head_next", 32'(read_addr), 1);
    tick();

    // Row 1: clean, retire stalled five cycles
    ret_ready = 1'b0;
    set_row(6'd1, {16'h0109, 16'h0108, 16'h0107, 16'h0106, 16'h0105,
                   16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100});
    expect_ret(6'd1, 1'b0, 4'd0, 16'h0000);
    head_done = 1'b1;
    @(negedge clk);
    check("r1_read_step", 32'(read_step), 1);
    check("r1_read_addr", 32'(read_addr), 1);
    tick();
    head_done = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(ret_valid), 1);
      check("hold_row",   32'(ret_row), 1);
      check("hold_exc",   32'(ret_exc), 0);
      check("hold_lane",  32'(ret_lane), 0);
      check("hold_data",  32'(ret_data), 0);
      check("hold_count", 32'(count), 2);
      check("hold_head",  32'(read_addr), 1);
      tick();
    end
    ret_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("r1_count_pop", 32'(count), 1);
    check("r1_head_next", 32'(read_addr), 2);
    tick();

    // Row 2: only the highest lane flagged
    set_row(6'd2, {16'hFFFF, {9{16'h7FFF}}});
    expect_ret(6'd2, 1'b1, 4'd9, 16'hFFFF);
    head_done = 1'b1;
    @(negedge clk);
    check("r2_read_step", 32'(read_step), 1);
    tick();
    head_done = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("r2_count_empty", 32'(count), 0);
    check("r2_head_next", 32'(read_addr), 3);
    tick();

    // Empty: head_done alone must not issue a read
    head_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("empty_no_read", 32'(read_step), 0);
      tick();
    end
    head_done = 1'b0;

    // Allocate then read next cycle: must observe the cleared row
`ifdef BOB_EXCEPT_SEQ_INIT_EN
    set_row(6'd3, {10{16'h8ABC}});
`else
    set_row(6'd3, '0);
`endif
    expect_ret(6'd3, 1'b0, 4'd0, 16'h0000);
    alloc_valid = 1'b1;
    head_done = 1'b1;
    ret_ready = 1'b1;
    @(negedge clk);
    check("r3_alloc_row", 32'(alloc_row), 3);
    check("r3_no_read_yet", 32'(read_step), 0);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("r3_read_step", 32'(read_step), 1);
    check("r3_read_addr", 32'(read_addr), 3);
`ifdef BOB_EXCEPT_SEQ_INIT_EN
    check("r3_init_wen", 32'(writeInit_wen), 1);
    check("r3_init_addr", 32'(writeInit_addr), 3);
`endif
    tick();
    head_done = 1'b0;
    tick();
    @(negedge clk);
    tick();

    // Flush in HOLD with alloc_valid and ret_ready asserted
    ret_ready = 1'b0;
    alloc_valid = 1'b1;
    tick();
    tick();
    alloc_valid = 1'b0;
    set_row(6'd4, {{7{16'h0000}}, 16'h8222, 16'h8111, 16'h0000});
    head_done = 1'b1;
    @(negedge clk);
    check("fl_read_step", 32'(read_step), 1);
    check("fl_read_addr", 32'(read_addr), 4);
    check("fl_count", 32'(count), 2);
    tick();
    head_done = 1'b0;
    tick();
    @(negedge clk);
    check("fl_hold_valid", 32'(ret_valid), 1);
    check("fl_hold_lane", 32'(ret_lane), 1);
    tick();
    flush = 1'b1;
    alloc_valid = 1'b1;
    ret_ready = 1'b1;
    @(negedge clk);
    check("fl_alloc_ready", 32'(alloc_ready), 0);
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    ret_ready = 1'b0;
    @(negedge clk);
    check("fl_count", 32'(count), 0);
    check("fl_ret_valid", 32'(ret_valid), 0);
    check("fl_tail", 32'(alloc_row), 0);
    check("fl_head", 32'(read_addr), 0);
    check("fl_init_wen", 32'(writeInit_wen), 0);
    check("fl_alloc_ready_after", 32'(alloc_ready), 1);
    tick();

    // Fill all 48 rows; tail wraps 47 -> 0
    alloc_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check("fill_alloc_row", 32'(alloc_row), i);
      tick();
    end
    @(negedge clk);
    check("full_count", 32'(count), 48);
    check("full_alloc_ready", 32'(alloc_ready), 0);
    check("full_tail_wrap", 32'(alloc_row), 0);
    tick();
    set_row(6'd0, {{3{16'h0000}}, 16'h8666, 16'h8555, {5{16'h0000}}});
    expect_ret(6'd0, 1'b1, 4'd5, 16'h8555);
    head_done = 1'b1;
    ret_ready = 1'b1;
    @(negedge clk);
    check("full_read_step", 32'(read_step), 1);
    check("full_ready_issue", 32'(alloc_ready), 0);
    tick();
    head_done = 1'b0;
    @(negedge clk);
    check("full_ready_rd", 32'(alloc_ready), 0);
    tick();
    @(negedge clk);
    check("full_ready_pop", 32'(alloc_ready), 0);
    check("full_count_pop", 32'(count), 48);
    tick();
    @(negedge clk);
    check("full_ready_after", 32'(alloc_ready), 1);
    check("full_regrant_row", 32'(alloc_row), 0);
    check("full_count_47", 32'(count), 47);
    tick();
    @(negedge clk);
    check("full_again", 32'(count), 48);
    check("full_tail_1", 32'(alloc_row), 1);
`ifdef BOB_EXCEPT_SEQ_INIT_EN
    check("full_init_wen", 32'(writeInit_wen), 1);
    check("full_init_addr", 32'(writeInit_addr), 0);
`endif
    tick();
    alloc_valid = 1'b0;

    // Asynchronous reset while in RD
    set_row(6'd1, {10{16'h8001}});
    head_done = 1'b1;
    @(negedge clk);
    check("ar_read_step", 32'(read_step), 1);
    tick();
    head_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_alloc_ready", 32'(alloc_ready), 1);
    check("ar_count", 32'(count), 0);
    check("ar_alloc_row", 32'(alloc_row), 0);
    check("ar_read_addr", 32'(read_addr), 0);
    check("ar_read_step", 32'(read_step), 0);
    check("ar_ret_valid", 32'(ret_valid), 0);
    check("ar_ret_row", 32'(ret_row), 0);
    check("ar_ret_exc", 32'(ret_exc), 0);
    check("ar_init_wen", 32'(writeInit_wen), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    head_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("ar_no_read", 32'(read_step), 0);
    end
    tick();
    set_row(6'd0, '0);
    expect_ret(6'd0, 1'b0, 4'd0, 16'h0000);
    alloc_valid = 1'b1;
    ret_ready = 1'b1;
    @(negedge clk);
    check("ar_pre_alloc_read", 32'(read_step), 0);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("ar_post_alloc_read", 32'(read_step), 1);
    check("ar_post_alloc_addr", 32'(read_addr), 0);
    tick();
    head_done = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("ar_final_count", 32'(count), 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bob_except_seq.md
# bob_except_seq

Retire-side sequencer for the 48-row × 10-lane exception store in the control block. It allocates rows in program order and clears each newly allocated row through the store's init write port. It then reads completed rows back in order, one row per retire, and reports to retire logic whether the row carries an exception, which lane holds the first one, and that lane's payload. Head and tail pointers plus occupancy are owned here. Lane write ports stay with the execution units.

## Interface
Parameters:
- DATA_WIDTH, `except_width: width of one lane record
- EXC_BIT, DATA_WIDTH-1: bit position of the exception flag inside a lane record

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- alloc_valid  in  1  request for one new row
- alloc_ready  out  1  row available; combinational, equals (count!=48)&&!flush
- alloc_row  out  6  row number granted, equals tail
- head_done  in  1  every lane of the head row is complete
- read_step  out  1  store read-address latch strobe
- read_addr  out  6  store read row
- read_data0..read_data9  in  DATA_WIDTH each  store lane outputs, valid the cycle after read_step
- writeInit_wen  out  1  init row write enable
- writeInit_addr  out  6  init row
- writeInit_data  out  DATA_WIDTH  init record, fanned out to all 10 lanes; all zero
- ret_valid  out  1  retire record valid
- ret_ready  in  1  retire logic accepts the record
- ret_row  out  6  row being retired
- ret_exc  out  1  at least one lane flagged
- ret_lane  out  4  lowest flagged lane, 0..9; 0 when ret_exc=0
- ret_data  out  DATA_WIDTH  record of ret_lane; 0 when ret_exc=0
- count  out  6  occupied rows, 0..48

## Operation
- Pointers: head and tail are 6-bit values in the range 0..47. Incrementing from 47 gives 0, never 48.
- Allocation: fires when alloc_valid&&alloc_ready.
  - tail increments.
  - The clear of the granted row is registered for the next cycle: writeInit_wen=1 and writeInit_addr equals the old tail.
- Count: an allocation and a retire pop in the same cycle leave count unchanged. Otherwise count moves by ±1.
- Retire FSM has three states: IDLE, RD, HOLD.
  - IDLE: when count!=0, head_done=1 and flush=0, drive read_step=1 and read_addr=head (combinational), then go to RD.
  - RD: sample read_data0..9. Compute ret_exc as the OR of the EXC_BIT flags. Select the lowest flagged lane through a priority encoder. Register ret_row, ret_exc, ret_lane and ret_data, set ret_valid=1, then go to HOLD.
  - HOLD: hold all ret_* outputs stable. When ret_ready=1, clear ret_valid, increment head, decrement count, and go to IDLE.
- read_step is 0 in every state other than the IDLE issue cycle. read_addr shows head whenever read_step=0.
- Flush, in any state:
  - head, tail and count go to 0; the FSM goes to IDLE; ret_valid is cleared.
  - Any pending init write is cancelled.
  - Flush wins over alloc_valid and ret_ready in the same cycle.
- Reset: every register is 0 and the FSM is in IDLE. All outputs are 0 except alloc_ready=1.

## Timing
- Allocation accepted in cycle N: alloc_row is valid in N, writeInit_wen is asserted in N+1, and the row is cleared at the end of N+1.
- Retire: read_step in cycle N, data sampled in N+1, ret_valid rises in N+2. With ret_ready tied high the pop happens in N+2, and the next read_step can come no earlier than N+3. Throughput is one row per 3 cycles.
- Init/read ordering: a row allocated in N can first be read-stepped in N+1. Its data is seen in N+2, after the clear has landed. The bench checks that the cleared value is what is read.
- Full: when count=48, alloc_ready=0. A pop in the same cycle does not raise alloc_ready until the next cycle.
- Empty: when count=0, no read_step is issued, regardless of head_done.

## Configuration
- BOB_EXCEPT_SEQ_INIT_EN
  - Defined: allocation clears the row as described under Operation.
  - Undefined: writeInit_wen is tied to 0 and writeInit_addr/writeInit_data are tied to 0; execution units must write all 10 lanes of every row before head_done.

## Test plan
- Reset, then 3 allocations back-to-back → alloc_row 0,1,2; writeInit_wen asserted for rows 0,1,2 one cycle later; count=3.
- Row 0 with lanes 3 and 7 flagged, head_done=1, ret_ready=1 → read_step, then 2 cycles later ret_valid with ret_row=0, ret_exc=1, ret_lane=3, ret_data equal to the lane 3 record.
- Clean row, then ret_ready held low for 5 cycles → ret_valid and all ret_* held stable, head unchanged, count unchanged until ret_ready rises.
- 48 allocations → alloc_ready=0 at count=48. Then one retire together with alloc_valid → the allocation is granted the cycle after the pop, tail wraps 47→0.
- flush asserted in HOLD with alloc_valid=1 and ret_ready=1 → next cycle head=tail=count=0, ret_valid=0, no allocation, no init write.
- rst asserted in RD → all outputs 0 immediately, asynchronously; after release, alloc_ready=1 and no read_step until an allocation is made.
